// File: rtl/emu_ctrl_pkg.sv
// Shared types for the emulation control sequencer: command opcodes,
// sequencer states and the packed queue-entry helper.
`ifndef TIME_WIDTH
`define TIME_WIDTH 16
`endif
`ifndef DEC_WIDTH
`define DEC_WIDTH 8
`endif

package emu_ctrl_pkg;

  localparam int TW = `TIME_WIDTH;
  localparam int CW = `TIME_WIDTH + 2;

  typedef enum logic [1:0] {
    OP_FREE     = 2'b00,
    OP_STALL    = 2'b01,
    OP_RUN_TO   = 2'b10,
    OP_FIXED_DT = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_WAIT = 2'b10
  } seq_state_e;

  // Queue entries carry the opcode in the top two bits.
  function automatic logic [CW-1:0] pack_cmd(input logic [1:0] op, input logic [TW-1:0] data);
    return {op, data};
  endfunction

endpackage

// File: rtl/emu_ctrl_if.sv
// Host command handshake: the host is master, the sequencer is slave.
interface emu_ctrl_if;
  logic                   cmd_valid;
  logic [1:0]             cmd_op;
  logic [`TIME_WIDTH-1:0] cmd_data;
  logic                   cmd_ready;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/emu_ctrl_fifo.sv
// Registered command queue with flush; full refuses pushes, empty refuses pops.
module emu_ctrl_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == (AW+1)'(0));
  assign o_level   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= (AW+1)'(0);
    end else if (i_flush) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= (AW+1)'(0);
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/emu_ctrl_seq.sv
// Emulation control sequencer: queues host commands and drives the downstream
// control stage, waiting on emulation time for RUN_TO targets.
module emu_ctrl_seq
  import emu_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            emu_clk,
  input  logic                            emu_rst_n,
  emu_ctrl_if.slave                       cmd,
  input  logic                            seq_abort,
  input  logic [`DEC_WIDTH-1:0]           dec_thr_in,
  input  logic                            dec_thr_we,
  input  logic [`TIME_WIDTH-1:0]          emu_time,
  output logic [1:0]                      emu_ctrl_mode,
  output logic [`TIME_WIDTH-1:0]          emu_ctrl_data,
  output logic [`DEC_WIDTH-1:0]           emu_dec_thr,
  output logic                            cmd_done,
  output logic                            seq_waiting,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
  seq_state_e           r_state;
  cmd_op_e              r_mode;
  logic [TW-1:0]        r_data;
  logic [`DEC_WIDTH-1:0] r_dec_thr;
  logic                 r_done;
  logic                 r_waiting;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [CW-1:0]        w_head;
  cmd_op_e              w_head_op;
  logic [TW-1:0]        w_head_data;

  assign cmd.cmd_ready = !w_full && !seq_abort;
  assign w_push        = cmd.cmd_valid && !w_full && !seq_abort;
  assign w_pop         = (r_state != ST_WAIT) && !w_empty && !seq_abort;
  assign w_head_op     = cmd_op_e'(w_head[CW-1 -: 2]);
  assign w_head_data   = w_head[TW-1:0];

  emu_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CW)
  ) u_fifo (
    .i_clk   (emu_clk),
    .i_rst_n (emu_rst_n),
    .i_flush (seq_abort),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (pack_cmd(cmd.cmd_op, cmd.cmd_data)),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Sequencer: abort beats everything; only IDLE/HOLD may pop the queue head.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= OP_STALL;
      r_data    <= TW'(0);
      r_done    <= 1'b0;
      r_waiting <= 1'b0;
    end else if (seq_abort) begin
      r_state   <= ST_IDLE;
      r_mode    <= OP_STALL;
      r_data    <= TW'(0);
      r_done    <= 1'b0;
      r_waiting <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (!w_empty) begin
            r_mode <= w_head_op;
            r_data <= w_head_data;
            if (w_head_op == OP_RUN_TO) begin
              r_state   <= ST_WAIT;
              r_waiting <= 1'b1;
            end else begin
              r_state <= ST_HOLD;
              r_done  <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (emu_time >= r_data) begin
            r_mode    <= OP_STALL;
            r_state   <= ST_IDLE;
            r_waiting <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_waiting <= 1'b0;
        end
      endcase
    end
  end

  // Decimation threshold is loaded independently of the sequencer state.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      r_dec_thr <= `DEC_WIDTH'(0);
    end else if (dec_thr_we) begin
      r_dec_thr <= dec_thr_in;
    end
  end

  assign emu_ctrl_mode = r_mode;
  assign emu_ctrl_data = r_data;
  assign emu_dec_thr   = r_dec_thr;
  assign cmd_done      = r_done;
  assign seq_waiting   = r_waiting;
endmodule

// File: doc/emu_ctrl_seq.md
EMU_CTRL_SEQ -- requirements
Module: emu_ctrl_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set command-queue depth (power of two, >=2).
REQ-002 Macros `TIME_WIDTH and `DEC_WIDTH SHALL set data widths; CW = `TIME_WIDTH+2.
REQ-003 emu_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 emu_rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 cmd_valid  in  1  SHALL qualify a host command.
REQ-006 cmd_op  in  2  SHALL be the opcode: 00 FREE, 01 STALL, 10 RUN_TO, 11 FIXED_DT.
REQ-007 cmd_data  in  `TIME_WIDTH  SHALL be the target time (RUN_TO) or timestep (FIXED_DT).
REQ-008 cmd_ready  out  1  SHALL indicate a command is accepted this edge when cmd_valid=1.
REQ-009 seq_abort  in  1  SHALL flush the queue and force STALL.
REQ-010 dec_thr_in  in  `DEC_WIDTH  and  dec_thr_we  in  1  SHALL load the decimation threshold.
REQ-011 emu_time  in  `TIME_WIDTH  SHALL be the current emulation time.
REQ-012 emu_ctrl_mode  out  2, emu_ctrl_data  out  `TIME_WIDTH, emu_dec_thr  out  `DEC_WIDTH  SHALL drive the downstream control stage; all registered.
REQ-013 cmd_done  out  1  SHALL pulse one cycle per completed command.
REQ-014 seq_waiting  out  1  SHALL be high while in WAIT.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH)+1  SHALL report queue occupancy.

Function
REQ-016 Queue: cmd_ready = !full && !seq_abort; accepted {op,data} is written at the accepting edge; no write when full, so commands are never dropped.
REQ-017 FSM states SHALL be IDLE, HOLD, WAIT.
REQ-018 In IDLE or HOLD with queue non-empty, the head SHALL be popped and loaded into emu_ctrl_mode/emu_ctrl_data at that edge; latency from accepting edge to output update = 1 cycle when the queue was empty.
REQ-019 Popped FREE/STALL/FIXED_DT SHALL go to HOLD and pulse cmd_done on the cycle after the load; outputs persist until the next pop.
REQ-020 Popped RUN_TO SHALL go to WAIT; no pops while in WAIT.
REQ-021 In WAIT, when emu_time >= emu_ctrl_data (unsigned, full width), next edge: emu_ctrl_mode=01, emu_ctrl_data unchanged, cmd_done=1, state -> IDLE.
REQ-022 RUN_TO with target <= current emu_time SHALL complete on the first WAIT cycle (1 cycle after load).
REQ-023 Queue empty in HOLD: outputs held, state stays HOLD.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 seq_abort=1 at an edge SHALL empty the queue, set mode=01, data=0, state IDLE, no cmd_done; abort wins over push and pop in the same cycle.
REQ-026 dec_thr_we=1 SHALL load emu_dec_thr next edge in any state, independent of the FSM.

Reset
REQ-027 On emu_rst_n=0 (asynchronous): state IDLE, queue empty, emu_ctrl_mode=01, emu_ctrl_data=0, emu_dec_thr=0, cmd_done=0, seq_waiting=0, fifo_level=0.
REQ-028 Reset mid-WAIT or mid-queue SHALL discard all pending commands; cmd_ready SHALL be 1 on the first cycle after release.

Structure
REQ-029 Package emu_ctrl_pkg SHALL hold the opcode enum (FREE, STALL, RUN_TO, FIXED_DT) and the FSM state enum.
REQ-030 The queue SHALL be a sub-module emu_ctrl_fifo (synchronous, registered, flush input); the FSM and output registers live in emu_ctrl_seq.

Verification
REQ-031 Reset release, no commands -> mode=01, data=0, cmd_ready=1, fifo_level=0.
REQ-032 Push RUN_TO data=100, emu_time ramps 0..120 -> mode=10 one cycle after accept, seq_waiting=1; after emu_time=100 is seen: mode=01, one cmd_done pulse.
REQ-033 Push RUN_TO 50 then FIXED_DT 8 with emu_time=70 -> RUN_TO completes 1 cycle after load, then mode=11, data=8, two cmd_done pulses total.
REQ-034 FIFO_DEPTH=4, WAIT on unreachable target, push 5 commands -> cmd_ready=0 after the 4th, fifo_level=4, 5th held by the host.
REQ-035 seq_abort while WAIT with 3 queued, cmd_valid=1 same cycle -> fifo_level=0, mode=01, data=0, IDLE, no cmd_done, command not accepted.
REQ-036 dec_thr_we with dec_thr_in=7 during WAIT -> emu_dec_thr=7 next cycle, FSM unaffected.
